// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single write port of the register file: latch winner, strobe, await wr_success, ack.
// Optional build macro WR_TIMEOUT_EN adds a WAIT-state timeout that completes the write with err set.
module regfile_write_arbiter #(
  parameter int NREQ    = 4,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        ack,
  output logic                   err,
  output logic [NREQ-1:0]        grant,
  output logic                   busy,
  output logic                   WR_en,
  output logic [ADDR_W-1:0]      WR_addr,
  output logic [DATA_W-1:0]      WR_data,
  input  logic                   wr_success
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [NREQ-1:0]     grant_r, grant_s;
  logic [NREQ-1:0]     ack_r, ack_s;
  logic                busy_r;
  logic                wr_en_r, wr_en_s;
  logic [ADDR_W-1:0]   wr_addr_r, wr_addr_s;
  logic [DATA_W-1:0]   wr_data_r, wr_data_s;
  logic [IDX_W-1:0]    last_r, last_s;
  logic [IDX_W-1:0]    win_r, win_s;
  logic [IDX_W-1:0]    pick_s;
  logic                timeout_s;

  // Nearest requester after 'last', wrapping modulo NREQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDX_W-1:0] last);
    int best_d;
    int d;
    rr_pick = last;
    best_d  = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      d = (i + NREQ - int'(last) - 1) % NREQ;
      if (r[i] && (d < best_d)) begin
        best_d  = d;
        rr_pick = IDX_W'(i);
      end else begin
        best_d = best_d;
      end
    end
  endfunction

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_s   = state_r;
    grant_s   = grant_r;
    ack_s     = '0;
    wr_en_s   = 1'b0;
    wr_addr_s = wr_addr_r;
    wr_data_s = wr_data_r;
    last_s    = last_r;
    win_s     = win_r;
    pick_s    = rr_pick(req, last_r);
    case (state_r)
      IDLE: begin
        if (|req) begin
          state_s = ISSUE;
          win_s   = pick_s;
          wr_en_s = 1'b1;
          for (int i = 0; i < NREQ; i++) begin
            if (IDX_W'(i) == pick_s) begin
              grant_s[i] = 1'b1;
              wr_addr_s  = req_addr[i*ADDR_W +: ADDR_W];
              wr_data_s  = req_data[i*DATA_W +: DATA_W];
            end else begin
              grant_s[i] = 1'b0;
            end
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        state_s = WAIT;
      end
      WAIT: begin
        // wr_success only counts once the strobe has gone back low
        if (wr_success) begin
          state_s = DONE;
          ack_s   = grant_r;
        end else if (timeout_s) begin
          state_s = DONE;
          ack_s   = grant_r;
        end else begin
          state_s = WAIT;
        end
      end
      DONE: begin
        state_s = IDLE;
        grant_s = '0;
        last_s  = win_r;
      end
      default: begin
        state_s = IDLE;
        grant_s = '0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any write in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      grant_r   <= '0;
      ack_r     <= '0;
      busy_r    <= 1'b0;
      wr_en_r   <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= '0;
      last_r    <= IDX_W'(NREQ - 1);
      win_r     <= '0;
    end else begin
      state_r   <= state_s;
      grant_r   <= grant_s;
      ack_r     <= ack_s;
      busy_r    <= (state_s != IDLE);
      wr_en_r   <= wr_en_s;
      wr_addr_r <= wr_addr_s;
      wr_data_r <= wr_data_s;
      last_r    <= last_s;
      win_r     <= win_s;
    end
  end

`ifdef WR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_r;
  logic             err_r;

  assign timeout_s = (cnt_r == CNT_W'(TIMEOUT - 1));

  // WAIT-cycle counter, zero outside WAIT; err flags a timed-out completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
      err_r <= 1'b0;
    end else begin
      err_r <= (state_r == WAIT) && !wr_success && timeout_s;
      if (state_r == WAIT) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= '0;
      end
    end
  end

  assign err = err_r;
`else
  logic timeout_unused_s;

  assign timeout_unused_s = (TIMEOUT > 0);
  assign timeout_s        = 1'b0;
  assign err              = 1'b0;
`endif

  assign grant   = grant_r;
  assign ack     = ack_r;
  assign busy    = busy_r;
  assign WR_en   = wr_en_r;
  assign WR_addr = wr_addr_r;
  assign WR_data = wr_data_r;

endmodule
